excess3_decoder: RTL and testbench

EXCESS3_DECODER -- requirements
Module: excess3_decoder

---
 rtl/excess3_decoder.sv | 204 ++++++++++++++++++++
 tb/tb_excess3_decoder.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/excess3_decoder.sv
// ---------------------------------------------------------------------------
// excess3_decoder
//
// Purpose:
//   Converts a stream of excess-3 coded decimal digits into an unsigned
//   binary number. The most significant digit arrives first. The final digit
//   is marked with in_last. One cycle after that digit is accepted, the
//   result is presented on out_bin/out_err with a valid/ready handshake. The
//   result is held until downstream accepts it.
//
// Parameters:
//   MAX_DIGITS - maximum decimal digits per number. The legal range is 1..4.
//
// Ports:
//   clk       in   1  clock; all state changes on its rising edge
//   rst       in   1  asynchronous active-high reset
//   in_valid  in   1  in_digit / in_last are valid this cycle
//   in_ready  out  1  block can accept a digit this cycle
//   in_digit  in   4  one excess-3 coded digit
//   in_last   in   1  this digit is the last one of the number
//   out_valid out  1  out_bin / out_err carry a finished result
//   out_ready in   1  downstream takes the result this cycle
//   out_bin   out 14  decoded value (0 when out_valid is low)
//   out_err   out  1  invalid code or too many digits (0 when out_valid low)
//
// Build option:
//   EXCESS3_DECODER_ERR_CHECK_EN
//     Defined: each digit is checked against the excess-3 code range
//     0011..1100, and the number of digits is checked against MAX_DIGITS.
//     Any violation sets a sticky error flag for the rest of the number.
//     An erroneous number is reported as out_err=1 with out_bin=0.
//     Undefined: no checking is done. Digit values wrap modulo 16, the
//     accumulator wraps modulo 2^14, and out_err is always 0.
// ---------------------------------------------------------------------------
module excess3_decoder #(
    parameter int MAX_DIGITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_digit,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [13:0] out_bin,
    output logic        out_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // The digit counter must reach MAX_DIGITS+1, which is at most 5,
    // so three bits are enough.
    localparam logic [2:0] CNT_MAX = 3'(MAX_DIGITS);
    localparam logic [2:0] CNT_SAT = 3'(MAX_DIGITS + 1);

    state_t      state_q, state_d;
    logic [13:0] acc_q, acc_d;
    logic [2:0]  cnt_q, cnt_d;

    logic        accept;
    logic [3:0]  digitVal;
    logic [13:0] accShift;

    // A digit is taken only when both sides of the input handshake agree.
    assign accept   = in_valid & in_ready;

    // The 4-bit subtraction makes out-of-range codes wrap modulo 16.
    // That wrap is the required behaviour when checking is compiled out.
    assign digitVal = in_digit - 4'd3;

    // The multiply-accumulate is kept to 14 bits, so it wraps modulo 2^14.
    assign accShift = (acc_q * 14'd10) + {10'd0, digitVal};

    // State, accumulator and digit counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= 14'd0;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic for the datapath.
    // IDLE loads the first digit. ACCUM folds in each further digit.
    // HOLD waits for the result handshake and then clears everything, so
    // the next number starts from a clean state.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    acc_d   = {10'd0, digitVal};
                    cnt_d   = 3'd1;
                    state_d = in_last ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_d = accShift;
                    // Saturate one past the limit. That is enough to
                    // remember that the number was too long.
                    if (cnt_q < CNT_SAT) begin
                        cnt_d = cnt_q + 3'd1;
                    end
                    if (in_last) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                // out_valid is high throughout HOLD, so out_ready alone
                // completes the output handshake here.
                if (out_ready) begin
                    state_d = IDLE;
                    acc_d   = 14'd0;
                    cnt_d   = 3'd0;
                end
            end
            default: begin
                state_d = IDLE;
                acc_d   = 14'd0;
                cnt_d   = 3'd0;
            end
        endcase
    end

`ifdef EXCESS3_DECODER_ERR_CHECK_EN
    logic err_q, err_d;
    logic codeBad;
    logic overflow;

    // Legal excess-3 codes are 0011 (digit 0) through 1100 (digit 9).
    assign codeBad  = (in_digit < 4'd3) || (in_digit > 4'd12);

    // cnt_q counts the digits already taken. If it has reached the limit,
    // the digit now arriving is one too many.
    assign overflow = (cnt_q >= CNT_MAX);

    // Sticky error flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    // The first digit restarts the flag. Later digits can only set it.
    // The flag is cleared again when the result leaves.
    always_comb begin
        err_d = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    err_d = codeBad;
                end
            end
            ACCUM: begin
                if (accept) begin
                    err_d = err_q | codeBad | overflow;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    err_d = 1'b0;
                end
            end
            default: begin
                err_d = 1'b0;
            end
        endcase
    end

    // Output decode. An erroneous number hides its value, and both
    // outputs read as zero whenever there is no result.
    always_comb begin
        in_ready  = (state_q != HOLD);
        out_valid = (state_q == HOLD);
        out_err   = out_valid & err_q;
        out_bin   = (out_valid && !err_q) ? acc_q : 14'd0;
    end
`else
    // Output decode without checking. Both outputs read as zero whenever
    // there is no result.
    always_comb begin
        in_ready  = (state_q != HOLD);
        out_valid = (state_q == HOLD);
        out_err   = 1'b0;
        out_bin   = out_valid ? acc_q : 14'd0;
    end
`endif

endmodule

// File: tb/tb_excess3_decoder.sv
// ---------------------------------------------------------------------------
// tb_excess3_decoder
//
// Directed testbench for excess3_decoder.
//
// A queue-based reference model collects the accepted digits. When a number
// ends, the model evaluates it arithmetically. A per-cycle compare process
// checks the DUT against the model on every falling edge. On top of that,
// hand-computed literal results pin down the model itself.
// ---------------------------------------------------------------------------
module tb_excess3_decoder;

    localparam int MAX_DIGITS = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_digit;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [13:0] out_bin;
    logic        out_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    excess3_decoder #(.MAX_DIGITS(MAX_DIGITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_digit  (in_digit),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bin   (out_bin),
        .out_err   (out_err)
    );

    // Reference model.
    // mDigits holds the codes of the number in progress. mHold means a
    // finished result is waiting for downstream to take it.
    logic [3:0]  mDigits[$];
    bit          mHold = 1'b0;
    logic [13:0] mBin  = 14'd0;
    logic        mErr  = 1'b0;

    // Evaluate a whole number from its list of codes using plain decimal
    // arithmetic. Each digit value is (code - 3) mod 16, and the running
    // value wraps at 2^14.
    function automatic void computeResult(input logic [3:0] ds[$],
                                          output logic [13:0] bin,
                                          output logic err);
        int value;
        int d;
        value = 0;
        err   = 1'b0;
        foreach (ds[i]) begin
            d     = (int'(ds[i]) + 13) % 16;
            value = (value * 10 + d) % 16384;
`ifdef EXCESS3_DECODER_ERR_CHECK_EN
            if (d > 9) err = 1'b1;
`endif
        end
`ifdef EXCESS3_DECODER_ERR_CHECK_EN
        if (ds.size() > MAX_DIGITS) err = 1'b1;
        bin = err ? 14'd0 : 14'(value);
`else
        bin = 14'(value);
`endif
    endfunction

    // Model update. Inputs are driven 1 time unit after each rising edge,
    // so they are stable when the model samples them here.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mHold = 1'b0;
            mDigits.delete();
            mBin  = 14'd0;
            mErr  = 1'b0;
        end else if (mHold) begin
            if (out_ready) mHold = 1'b0;
        end else if (in_valid) begin
            mDigits.push_back(in_digit);
            if (in_last) begin
                computeResult(mDigits, mBin, mErr);
                mHold = 1'b1;
                mDigits.delete();
            end
        end
    end

    // Per-cycle compare against the model, on the falling edge.
    logic        expValid;
    logic        expReady;
    logic [13:0] expBin;
    logic        expErr;

    always @(negedge clk) begin
        expValid = mHold;
        expReady = !mHold;
        expBin   = mHold ? mBin : 14'd0;
        expErr   = mHold ? mErr : 1'b0;
        checks++;
        if (out_valid !== expValid || in_ready !== expReady ||
            out_bin !== expBin || out_err !== expErr) begin
            failures++;
            $display("[TB] FAIL cycleModel t=%0t got valid=%b ready=%b bin=%0d err=%b expected valid=%b ready=%b bin=%0d err=%b",
                     $time, out_valid, in_ready, out_bin, out_err,
                     expValid, expReady, expBin, expErr);
        end
    end

    // Compare the current outputs against hand-computed literal values.
    task automatic checkOutput(input string name, input logic eValid,
                               input logic eReady, input logic [13:0] eBin,
                               input logic eErr);
        checks++;
        if (out_valid !== eValid || in_ready !== eReady ||
            out_bin !== eBin || out_err !== eErr) begin
            failures++;
            $display("[TB] FAIL %s got valid=%b ready=%b bin=%0d err=%b expected valid=%b ready=%b bin=%0d err=%b",
                     name, out_valid, in_ready, out_bin, out_err,
                     eValid, eReady, eBin, eErr);
        end
    endtask

    // Offer one digit after an optional gap of idle cycles. During the gap,
    // in_digit and in_last carry junk. The wait for in_ready is bounded by a
    // cycle budget. The task returns 1 time unit after the edge that took
    // the digit.
    task automatic applyStimulus(input logic [3:0] digit, input logic last,
                                 input int gap);
        int n;
        repeat (gap) begin
            in_valid = 1'b0;
            in_digit = 4'($urandom_range(0, 15));
            in_last  = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (!in_ready) begin
            failures++;
            $display("[TB] FAIL readyTimeout got ready=%b expected ready=1 within 20 cycles", in_ready);
        end
        in_valid = 1'b1;
        in_digit = digit;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Step one cycle and confirm that the result has gone and the block is
    // back in IDLE.
    task automatic expectDone(input string name);
        @(posedge clk);
        #1;
        checkOutput(name, 1'b0, 1'b1, 14'd0, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_digit  = 4'd0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("resetState", 1'b0, 1'b1, 14'd0, 1'b0);
        rst = 1'b0;
        #1;
        checkOutput("readyAfterReset", 1'b0, 1'b1, 14'd0, 1'b0);

        // 7,5,10 -> 4,2,7 -> 427. Gaps are inserted between the digits.
        $display("[TB] number 427 with gaps");
        applyStimulus(4'b0111, 1'b0, 0);
        applyStimulus(4'b0101, 1'b0, 2);
        applyStimulus(4'b1010, 1'b1, 1);
        checkOutput("dec427", 1'b1, 1'b0, 14'd427, 1'b0);
        expectDone("dec427Done");

        // Four nines: the largest legal number.
        $display("[TB] number 9999");
        for (int i = 0; i < 4; i++) applyStimulus(4'b1100, (i == 3), 0);
        checkOutput("dec9999", 1'b1, 1'b0, 14'd9999, 1'b0);
        expectDone("dec9999Done");

        // Codes 0100,0000,0101. Without checking, the digit values are
        // 1,13,2, giving ((1*10)+13)*10+2 = 232.
        $display("[TB] number with invalid middle code");
        applyStimulus(4'b0100, 1'b0, 0);
        applyStimulus(4'b0000, 1'b0, 0);
        applyStimulus(4'b0101, 1'b1, 0);
`ifdef EXCESS3_DECODER_ERR_CHECK_EN
        checkOutput("badCode", 1'b1, 1'b0, 14'd0, 1'b1);
`else
        checkOutput("badCode", 1'b1, 1'b0, 14'd232, 1'b0);
`endif
        expectDone("badCodeDone");

        // Five ones: one digit too many. Without checking, the result
        // is 11111.
        $display("[TB] five digit overflow");
        for (int i = 0; i < 5; i++) applyStimulus(4'b0100, (i == 4), 0);
`ifdef EXCESS3_DECODER_ERR_CHECK_EN
        checkOutput("overflow", 1'b1, 1'b0, 14'd0, 1'b1);
`else
        checkOutput("overflow", 1'b1, 1'b0, 14'd11111, 1'b0);
`endif
        expectDone("overflowDone");

        // A single code 1101 wraps to digit value 10.
        applyStimulus(4'b1101, 1'b1, 0);
`ifdef EXCESS3_DECODER_ERR_CHECK_EN
        checkOutput("highCode", 1'b1, 1'b0, 14'd0, 1'b1);
`else
        checkOutput("highCode", 1'b1, 1'b0, 14'd10, 1'b0);
`endif
        expectDone("highCodeDone");

        // Zero with backpressure. Junk input offered during HOLD must be
        // ignored.
        $display("[TB] backpressure hold");
        out_ready = 1'b0;
        applyStimulus(4'b0011, 1'b1, 0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_digit = 4'b1001;
            in_last  = 1'b1;
            checkOutput("holdStable", 1'b1, 1'b0, 14'd0, 1'b0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        checkOutput("holdLast", 1'b1, 1'b0, 14'd0, 1'b0);
        out_ready = 1'b1;
        expectDone("holdRelease");

        // Reset in the middle of a number discards the partial digits.
        $display("[TB] mid-number reset");
        applyStimulus(4'b0100, 1'b0, 0);
        applyStimulus(4'b0100, 1'b0, 0);
        rst = 1'b1;
        #1;
        checkOutput("midReset", 1'b0, 1'b1, 14'd0, 1'b0);
        #1;
        rst = 1'b0;
        applyStimulus(4'b0110, 1'b1, 0);
        checkOutput("afterReset3", 1'b1, 1'b0, 14'd3, 1'b0);
        expectDone("afterReset3Done");

        // Two back-to-back numbers: 1,2 -> 12, then 8 -> 8.
        applyStimulus(4'b0100, 1'b0, 0);
        applyStimulus(4'b0101, 1'b1, 0);
        checkOutput("dec12", 1'b1, 1'b0, 14'd12, 1'b0);
        applyStimulus(4'b1011, 1'b1, 0);
        checkOutput("dec8", 1'b1, 1'b0, 14'd8, 1'b0);
        expectDone("dec8Done");

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog got no finish expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
